// File: rtl/data_sram_responder.sv
// Data-side SRAM responder for the core: local word RAM plus a 4 KB register window
// (LED, switches, free-running timer, scratch). One-cycle registered read, byte-lane writes.
module data_sram_responder #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [31:0] MMIO_BASE = 32'hbfaf_f000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [7:0]  switch
);

    // Register offsets in word units (addr[11:2]).
    localparam logic [9:0] OFF_LED     = 10'h000;
    localparam logic [9:0] OFF_SWITCH  = 10'h001;
    localparam logic [9:0] OFF_TIMER   = 10'h002;
    localparam logic [9:0] OFF_SCRATCH = 10'h003;

    // Handshake: data_sram_en qualifies an access for exactly one cycle; there is no
    // ready, so every access is accepted in the cycle it is presented.
    logic              mmio_hit;
    logic [9:0]        word_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              is_read;
    logic              is_write;
    logic              mmio_wr;
    logic              ram_wr;
    logic [31:0]       ram_word;
    logic [31:0]       mmio_rdata;
    logic [31:0]       timer;
    logic [31:0]       scratch;
    logic [7:0]        sw_meta;
    logic [7:0]        sw_sync;
    logic              unused_addr_bits;

    logic [31:0] ram [0:(1 << RAM_AW) - 1];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

    assign mmio_hit         = (data_sram_addr[31:12] == MMIO_BASE[31:12]);
    assign word_off         = data_sram_addr[11:2];
    assign ram_idx          = data_sram_addr[RAM_AW+1:2];
    assign is_read          = data_sram_en && (data_sram_wen == 4'h0);
    assign is_write         = data_sram_en && (data_sram_wen != 4'h0);
    assign mmio_wr          = is_write && mmio_hit && !rst;
    assign ram_wr           = is_write && !mmio_hit && !rst;
    assign ram_word         = ram[ram_idx];
    assign unused_addr_bits = ^data_sram_addr[1:0];

    // RAM contents are deliberately not reset; a write during reset is dropped via ram_wr.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) ram[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        mmio_rdata = 32'h0;
        case (word_off)
            OFF_LED:     mmio_rdata = {16'h0, led};
            OFF_SWITCH:  mmio_rdata = {24'h0, sw_sync};
            OFF_TIMER:   mmio_rdata = timer;
            OFF_SCRATCH: mmio_rdata = scratch;
            default:     mmio_rdata = 32'h0;
        endcase
    end

    // Load data only moves on read cycles, so it holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sram_rdata <= 32'h0;
        end else if (is_read) begin
            data_sram_rdata <= mmio_hit ? mmio_rdata : ram_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led <= 16'h0;
        end else if (mmio_wr && (word_off == OFF_LED)) begin
            if (data_sram_wen[0]) led[7:0]  <= data_sram_wdata[7:0];
            if (data_sram_wen[1]) led[15:8] <= data_sram_wdata[15:8];
        end
    end

    // A timer write replaces the increment for that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= 32'h0;
        end else if (mmio_wr && (word_off == OFF_TIMER)) begin
            timer <= merge_bytes(timer, data_sram_wdata, data_sram_wen);
        end else begin
            timer <= timer + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch <= 32'h0;
        end else if (mmio_wr && (word_off == OFF_SCRATCH)) begin
            scratch <= merge_bytes(scratch, data_sram_wdata, data_sram_wen);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_meta <= 8'h0;
            sw_sync <= 8'h0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
        end
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the core's data SRAM port (en / wen / addr / wdata / rdata).
- Services loads and stores from the core's EX/MEM stages with fixed 1-cycle read latency.
- Backed by a local word-organised RAM plus a small memory-mapped register window: LED, switches, free-running timer, scratch.
- Sits beside the core at SoC top level; drives the core's data_sram_rdata.

Parameters:
- RAM_AW, 12, word-address width of the local RAM (depth 2^RAM_AW words).
- MMIO_BASE, 32'hbfaf_f000, base of the 4 KB register window (low 12 bits must be zero).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous reset, active-high
- data_sram_en  input  1  access valid this cycle
- data_sram_wen  input  4  byte write enables; lane i = bits [8i+7:8i]; 0 = read
- data_sram_addr  input  32  byte address; bits [1:0] ignored
- data_sram_wdata  input  32  store data, already lane-aligned by the core
- data_sram_rdata  output  32  load data, registered
- led  output  16  LED register contents
- switch  input  8  asynchronous board switches

Behaviour:
- Reset (rst=1 at an edge):
  - data_sram_rdata=0, led=0, timer=0, scratch=0; switch synchroniser flops=0.
  - RAM contents are not reset.
  - Any access presented in a reset cycle is dropped.
- Decode:
  - mmio_hit = (addr[31:12] == MMIO_BASE[31:12]).
  - Otherwise the access targets RAM at word index addr[RAM_AW+1:2]. Upper bits are ignored, so aliasing is accepted.
- Read (en=1, wen=0) in cycle N: data_sram_rdata shows the selected word after the edge ending cycle N, i.e. valid throughout cycle N+1.
- Write (en=1, wen!=0) in cycle N: only enabled byte lanes update at the edge ending cycle N; other lanes are unchanged.
- data_sram_rdata holds its last read value on write cycles and idle cycles (en=0).
- Back-to-back write then read of the same address: the read returns the newly written bytes.
- MMIO register map (offset = addr[11:0]):
  - 0x000 LED: RW. Bits [15:0] drive led; reads return {16'b0, led}; byte-lane writes to lanes 2/3 are ignored.
  - 0x004 SWITCH: RO. Reads return {24'b0, switch_sync}, where switch_sync is switch passed through a 2-flop synchroniser. Writes are ignored.
  - 0x008 TIMER: RW, 32-bit.
    - Increments by 1 every cycle, wrapping 32'hffff_ffff -> 0.
    - A write cycle loads the byte-merged value {enabled lanes from wdata, others from the current timer} and does not increment that cycle.
    - A read returns the pre-edge value.
  - 0x00c SCRATCH: RW, 32-bit, byte-enabled.
  - Any other offset: reads return 0; writes are ignored.
- No backpressure: the responder accepts an access every cycle; no stall request is generated.
- en=0: no state change except timer increment and the switch synchroniser.

Test Plan:
- Reset then RAM write/read:
  - Stimulus: write wen=4'hf, addr=0x0000_0010, wdata=0xdead_beef; read the same address next cycle.
  - Response: rdata=0xdead_beef in the cycle after the read. rdata=0 before any read after reset.
- Byte lanes:
  - Stimulus: preload 0x1122_3344; write wen=4'b0101, wdata=0xaabb_ccdd; then read.
  - Response: 0x11bb_33dd.
- LED:
  - Stimulus: write addr=0xbfaf_f000, wdata=0xffff_a5a5, wen=4'hf.
  - Response: led=16'ha5a5 next cycle; read returns 0x0000_a5a5.
- Timer:
  - Stimulus A: reset; read timer in cycle 10 after reset release → returns 10.
  - Stimulus B: write 0xffff_fffe; reads in the two following cycles → return 0xffff_fffe, then 0xffff_ffff; one cycle later the timer wraps to 0.
- Switch synchroniser:
  - Stimulus: change switch 0x00 -> 0x5a at cycle N; read 0xbfaf_f004 each cycle.
  - Response: 0x5a first appears in rdata on the read issued at cycle N+2 or later.
- Unmapped offset and reset mid-stream:
  - Stimulus A: read 0xbfaf_f100 → returns 0; write to it → changes nothing.
  - Stimulus B: assert rst in the same cycle as a RAM write → the RAM word is unchanged and rdata=0.
